// File: rtl/write_pkg.sv
// ---------------------------------------------------------------------------
// write_pkg
// Shared definitions for the DDR5 write burst engine:
//   - FSM state encoding
//   - burst-length encodings and the beats_of() helper
//   - DQS toggle constants used on data and CRC beats
//   - width of the shared cycle/beat counter
// ---------------------------------------------------------------------------
package write_pkg;

    // Wide enough for the longest state (BL32 = 32 beats) without wrapping.
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        POST = 3'd4
    } state_t;

    localparam logic [1:0] BL_16  = 2'b00;
    localparam logic [1:0] BL_BC8 = 2'b01;
    localparam logic [1:0] BL_32  = 2'b10;

    // {DQS_t, DQS_c} for even and odd beats.
    localparam logic [1:0] DQS_EVEN = 2'b10;
    localparam logic [1:0] DQS_ODD  = 2'b01;

    // Number of data beats for a burst-length code; the reserved code 11
    // falls back to BL16.
    function automatic logic [CNT_W-1:0] beats_of(input logic [1:0] bl);
        case (bl)
            BL_BC8:  beats_of = 6'd8;
            BL_32:   beats_of = 6'd32;
            default: beats_of = 6'd16;
        endcase
    endfunction

endpackage

// File: rtl/write_beat_counter.sv
// ---------------------------------------------------------------------------
// write_beat_counter
// Up-counter that tracks the cycle index inside the current FSM state
// (preamble cycle, data beat, CRC beat or postamble cycle).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, clears the count
//   enable       advance/hold; low freezes the count
//   load         restart the count at 0 on the next enabled edge
//   terminal     last index of the current state
//   count        current index
//   at_terminal  count equals terminal (last cycle of the state)
// ---------------------------------------------------------------------------
module write_beat_counter
    import write_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             at_terminal
);

    // The count saturates at the terminal value so it can never wrap,
    // even while the FSM sits in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            if (load) begin
                count <= '0;
            end else if (count != terminal) begin
                count <= count + 1'b1;
            end
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/write_burst_engine.sv
// ---------------------------------------------------------------------------
// write_burst_engine
// Sequences one DDR5 write burst across NUM_BYTES byte lanes:
// DQS preamble, data beats with mask, optional CRC beats, DQS postamble.
// Supports BL16, BC8, BL32 and seamless back-to-back writes.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_enable                high = advance, low = freeze everything
//   i_wr_en                 write command strobe
//   i_burstlength           00 BL16, 01 BC8, 10 BL32, 11 as BL16
//   i_precycle/postcycle    preamble/postamble lengths (clamped)
//   i_pre/post_pattern      DQS patterns, 2 bits per cycle
//   i_DRAM_crc_en           append CRC_BEATS CRC beats
//   i_Wr_data/datamask      write beat and per-lane mask
//   i_crc_code              CRC beat value from the external generator
//   o_DQ/o_DQ_valid/o_DM    data or CRC beat, valid, mask
//   o_DQS/o_DQS_valid       per-lane {DQS_t, DQS_c}, driven flag
//   o_crc_data/enable       data beat copy for the CRC generator
//   o_data_ready            upstream must present the next beat now
//   o_busy                  FSM not in IDLE
// ---------------------------------------------------------------------------
module write_burst_engine
    import write_pkg::*;
#(
    parameter int NUM_BYTES = 1,
    parameter int CRC_BEATS = 2,
    parameter int MAX_PRE   = 4,
    parameter int MAX_POST  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_wr_en,
    input  logic [1:0]             i_burstlength,
    input  logic [2:0]             i_precycle,
    input  logic [1:0]             i_postcycle,
    input  logic [2*MAX_PRE-1:0]   i_pre_pattern,
    input  logic [2*MAX_POST-1:0]  i_post_pattern,
    input  logic                   i_DRAM_crc_en,
    input  logic [8*NUM_BYTES-1:0] i_Wr_data,
    input  logic [NUM_BYTES-1:0]   i_Wr_datamask,
    input  logic [8*NUM_BYTES-1:0] i_crc_code,
    output logic [8*NUM_BYTES-1:0] o_DQ,
    output logic                   o_DQ_valid,
    output logic [NUM_BYTES-1:0]   o_DM,
    output logic [2*NUM_BYTES-1:0] o_DQS,
    output logic                   o_DQS_valid,
    output logic [8*NUM_BYTES-1:0] o_crc_data,
    output logic                   o_crc_enable,
    output logic                   o_data_ready,
    output logic                   o_busy
);

    localparam int DQ_W = 8 * NUM_BYTES;

    // Clamp limits expressed in the width of the corresponding inputs.
    localparam logic [2:0] PRE_LIMIT  = (MAX_PRE  > 7) ? 3'd7 : 3'(MAX_PRE);
    localparam logic [1:0] POST_LIMIT = (MAX_POST > 3) ? 2'd3 : 2'(MAX_POST);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_BEATS - 1);

    // FSM and latched configuration
    state_t                state_q, state_d;
    logic [1:0]            bl_q, bl_d;
    logic [2:0]            pre_n_q, pre_n_d, pre_clamped;
    logic [1:0]            post_n_q, post_n_d, post_clamped;
    logic [2*MAX_PRE-1:0]  pre_pat_q, pre_pat_d;
    logic [2*MAX_POST-1:0] post_pat_q, post_pat_d;
    logic                  crc_en_q, crc_en_d;
    logic                  phase_q, phase_d;

    // Counter interface
    logic [CNT_W-1:0]      count, terminal, idx_d;
    logic                  at_term, load;
    logic                  latch_cfg, burst_end, seamless;

    // Output registers and their next values
    logic [DQ_W-1:0]       dq_q, dq_d;
    logic [NUM_BYTES-1:0]  dm_q, dm_d;
    logic                  dq_valid_q, dq_valid_d;
    logic [1:0]            dqs_q, dqs_d;
    logic                  dqs_valid_q, dqs_valid_d;
    logic [DQ_W-1:0]       crc_data_q, crc_data_d;
    logic                  crc_enable_q, crc_enable_d;
    logic                  ready_q, ready_d;

    // Pattern slice k; a constant-index loop keeps the part-select static.
    function automatic logic [1:0] pre_slice(input logic [2*MAX_PRE-1:0] pat,
                                             input logic [CNT_W-1:0] idx);
        pre_slice = 2'b00;
        for (int k = 0; k < MAX_PRE; k++) begin
            if (idx == CNT_W'(k)) pre_slice = pat[2*k +: 2];
        end
    endfunction

    function automatic logic [1:0] post_slice(input logic [2*MAX_POST-1:0] pat,
                                              input logic [CNT_W-1:0] idx);
        post_slice = 2'b00;
        for (int k = 0; k < MAX_POST; k++) begin
            if (idx == CNT_W'(k)) post_slice = pat[2*k +: 2];
        end
    endfunction

    write_beat_counter u_counter (
        .clk         (i_clk),
        .rst         (i_rst),
        .enable      (i_enable),
        .load        (load),
        .terminal    (terminal),
        .count       (count),
        .at_terminal (at_term)
    );

    // Preamble 0 behaves as 1; both lengths saturate at their maxima.
    always_comb begin
        pre_clamped = i_precycle;
        if (i_precycle == 3'd0) begin
            pre_clamped = 3'd1;
        end else if (i_precycle > PRE_LIMIT) begin
            pre_clamped = PRE_LIMIT;
        end
        post_clamped = (i_postcycle > POST_LIMIT) ? POST_LIMIT : i_postcycle;
    end

    // Last index of the current state. Kept apart from the FSM process so
    // the counter's terminal flag never loops back into its own input.
    always_comb begin
        terminal = '0;
        case (state_q)
            PRE:     terminal = CNT_W'(pre_n_q) - 1'b1;
            DATA:    terminal = beats_of(bl_q) - 1'b1;
            CRC:     terminal = CRC_LAST;
            POST:    terminal = CNT_W'(post_n_q) - 1'b1;
            default: terminal = '0;
        endcase
    end

    // Next-state logic. A command on the final DATA/CRC beat re-enters DATA
    // directly; any other command while busy is dropped.
    always_comb begin
        state_d   = state_q;
        burst_end = at_term && ((state_q == DATA && !crc_en_q) || state_q == CRC);
        seamless  = burst_end && i_wr_en;
        case (state_q)
            IDLE: if (i_wr_en) state_d = PRE;
            PRE:  if (at_term) state_d = DATA;
            DATA: begin
                if (at_term) begin
                    if (seamless)            state_d = DATA;
                    else if (crc_en_q)       state_d = CRC;
                    else if (post_n_q != '0) state_d = POST;
                    else                     state_d = IDLE;
                end
            end
            CRC: begin
                if (at_term) begin
                    if (seamless)            state_d = DATA;
                    else if (post_n_q != '0) state_d = POST;
                    else                     state_d = IDLE;
                end
            end
            POST:    if (at_term) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        latch_cfg = (state_q == IDLE && i_wr_en) || seamless;
        load      = (state_d != state_q) || seamless;
        idx_d     = load ? '0 : count + 1'b1;

        bl_d       = latch_cfg ? i_burstlength  : bl_q;
        pre_n_d    = latch_cfg ? pre_clamped    : pre_n_q;
        post_n_d   = latch_cfg ? post_clamped   : post_n_q;
        pre_pat_d  = latch_cfg ? i_pre_pattern  : pre_pat_q;
        post_pat_d = latch_cfg ? i_post_pattern : post_pat_q;
        crc_en_d   = latch_cfg ? i_DRAM_crc_en  : crc_en_q;
    end

    // Outputs are computed for the cycle being entered so that every output
    // can be a plain register. DQS parity restarts at 0 only when DATA is
    // entered from the preamble; it keeps toggling through CRC and seamless.
    always_comb begin
        dq_d         = '0;
        dm_d         = '0;
        dq_valid_d   = 1'b0;
        dqs_d        = 2'b00;
        dqs_valid_d  = 1'b0;
        crc_data_d   = '0;
        crc_enable_d = 1'b0;
        ready_d      = 1'b0;
        phase_d      = 1'b0;
        case (state_d)
            PRE: begin
                dqs_d       = pre_slice(pre_pat_d, idx_d);
                dqs_valid_d = 1'b1;
                ready_d     = (idx_d == CNT_W'(pre_n_d) - 1'b1);
            end
            DATA: begin
                phase_d      = (state_q == DATA || state_q == CRC) ? ~phase_q : 1'b0;
                dq_d         = i_Wr_data;
                dm_d         = i_Wr_datamask;
                dq_valid_d   = 1'b1;
                crc_data_d   = i_Wr_data;
                crc_enable_d = 1'b1;
                dqs_d        = phase_d ? DQS_ODD : DQS_EVEN;
                dqs_valid_d  = 1'b1;
                ready_d      = (idx_d != beats_of(bl_d) - 1'b1);
            end
            CRC: begin
                phase_d     = ~phase_q;
                dq_d        = i_crc_code;
                dq_valid_d  = 1'b1;
                dqs_d       = phase_d ? DQS_ODD : DQS_EVEN;
                dqs_valid_d = 1'b1;
            end
            POST: begin
                dqs_d       = post_slice(post_pat_d, idx_d);
                dqs_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, configuration and output registers; i_enable low holds all.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            bl_q         <= BL_16;
            pre_n_q      <= 3'd1;
            post_n_q     <= '0;
            pre_pat_q    <= '0;
            post_pat_q   <= '0;
            crc_en_q     <= 1'b0;
            phase_q      <= 1'b0;
            dq_q         <= '0;
            dm_q         <= '0;
            dq_valid_q   <= 1'b0;
            dqs_q        <= 2'b00;
            dqs_valid_q  <= 1'b0;
            crc_data_q   <= '0;
            crc_enable_q <= 1'b0;
            ready_q      <= 1'b0;
        end else if (i_enable) begin
            state_q      <= state_d;
            bl_q         <= bl_d;
            pre_n_q      <= pre_n_d;
            post_n_q     <= post_n_d;
            pre_pat_q    <= pre_pat_d;
            post_pat_q   <= post_pat_d;
            crc_en_q     <= crc_en_d;
            phase_q      <= phase_d;
            dq_q         <= dq_d;
            dm_q         <= dm_d;
            dq_valid_q   <= dq_valid_d;
            dqs_q        <= dqs_d;
            dqs_valid_q  <= dqs_valid_d;
            crc_data_q   <= crc_data_d;
            crc_enable_q <= crc_enable_d;
            ready_q      <= ready_d;
        end
    end

    assign o_DQ         = dq_q;
    assign o_DM         = dm_q;
    assign o_DQ_valid   = dq_valid_q;
    assign o_DQS        = {NUM_BYTES{dqs_q}};
    assign o_DQS_valid  = dqs_valid_q;
    assign o_crc_data   = crc_data_q;
    assign o_crc_enable = crc_enable_q;
    assign o_busy       = (state_q != IDLE);

    // Whether a seamless command arrives is only known during the final
    // beat itself, so that one case is added to the registered ready.
    assign o_data_ready = ready_q | (seamless & i_enable);

endmodule

// File: tb/tb_write_burst_engine.sv
// ---------------------------------------------------------------------------
// tb_write_burst_engine
// Directed self-checking bench for write_burst_engine with two byte lanes.
// Inputs change 1 time unit after the rising edge, outputs are read there.
// ---------------------------------------------------------------------------
module tb_write_burst_engine;

    localparam int NB = 2;

    logic            i_clk;
    logic            i_rst;
    logic            i_enable;
    logic            i_wr_en;
    logic [1:0]      i_burstlength;
    logic [2:0]      i_precycle;
    logic [1:0]      i_postcycle;
    logic [7:0]      i_pre_pattern;
    logic [3:0]      i_post_pattern;
    logic            i_DRAM_crc_en;
    logic [8*NB-1:0] i_Wr_data;
    logic [NB-1:0]   i_Wr_datamask;
    logic [8*NB-1:0] i_crc_code;
    logic [8*NB-1:0] o_DQ;
    logic            o_DQ_valid;
    logic [NB-1:0]   o_DM;
    logic [2*NB-1:0] o_DQS;
    logic            o_DQS_valid;
    logic [8*NB-1:0] o_crc_data;
    logic            o_crc_enable;
    logic            o_data_ready;
    logic            o_busy;

    int checks      = 0;
    int failures    = 0;
    int busyCycles  = 0;
    int crcCycles   = 0;

    write_burst_engine #(
        .NUM_BYTES (NB),
        .CRC_BEATS (2),
        .MAX_PRE   (4),
        .MAX_POST  (2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_enable       (i_enable),
        .i_wr_en        (i_wr_en),
        .i_burstlength  (i_burstlength),
        .i_precycle     (i_precycle),
        .i_postcycle    (i_postcycle),
        .i_pre_pattern  (i_pre_pattern),
        .i_post_pattern (i_post_pattern),
        .i_DRAM_crc_en  (i_DRAM_crc_en),
        .i_Wr_data      (i_Wr_data),
        .i_Wr_datamask  (i_Wr_datamask),
        .i_crc_code     (i_crc_code),
        .o_DQ           (o_DQ),
        .o_DQ_valid     (o_DQ_valid),
        .o_DM           (o_DM),
        .o_DQS          (o_DQS),
        .o_DQS_valid    (o_DQS_valid),
        .o_crc_data     (o_crc_data),
        .o_crc_enable   (o_crc_enable),
        .o_data_ready   (o_data_ready),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Safety net in case the stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_busy)       busyCycles++;
        if (o_crc_enable) crcCycles++;
    endtask

    function automatic logic [15:0] beatData(input int id, input int j);
        return 16'((id << 12) + (j * 257) + 5);
    endfunction

    function automatic logic [3:0] dqsFor(input int idx);
        return (idx % 2 == 0) ? 4'b1010 : 4'b0101;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_dq"},       32'(o_DQ),         32'h0);
        checkOutput({tag, "_dqv"},      32'(o_DQ_valid),   32'h0);
        checkOutput({tag, "_dm"},       32'(o_DM),         32'h0);
        checkOutput({tag, "_dqs"},      32'(o_DQS),        32'h0);
        checkOutput({tag, "_dqsv"},     32'(o_DQS_valid),  32'h0);
        checkOutput({tag, "_crcdata"},  32'(o_crc_data),   32'h0);
        checkOutput({tag, "_crcen"},    32'(o_crc_enable), 32'h0);
        checkOutput({tag, "_ready"},    32'(o_data_ready), 32'h0);
        checkOutput({tag, "_busy"},     32'(o_busy),       32'h0);
    endtask

    task automatic expectDqs(input string tag, input logic [3:0] dqs, input logic ready);
        checkOutput({tag, "_dqs"},   32'(o_DQS),        32'(dqs));
        checkOutput({tag, "_dqsv"},  32'(o_DQS_valid),  32'h1);
        checkOutput({tag, "_dqv"},   32'(o_DQ_valid),   32'h0);
        checkOutput({tag, "_dq"},    32'(o_DQ),         32'h0);
        checkOutput({tag, "_ready"}, 32'(o_data_ready), 32'(ready));
        checkOutput({tag, "_busy"},  32'(o_busy),       32'h1);
    endtask

    task automatic expectBeat(input string tag, input logic [15:0] dq, input logic [1:0] dm,
                              input logic [3:0] dqs, input logic ready);
        checkOutput({tag, "_dq"},      32'(o_DQ),         32'(dq));
        checkOutput({tag, "_dqv"},     32'(o_DQ_valid),   32'h1);
        checkOutput({tag, "_dm"},      32'(o_DM),         32'(dm));
        checkOutput({tag, "_dqs"},     32'(o_DQS),        32'(dqs));
        checkOutput({tag, "_crcdata"}, 32'(o_crc_data),   32'(dq));
        checkOutput({tag, "_crcen"},   32'(o_crc_enable), 32'h1);
        checkOutput({tag, "_ready"},   32'(o_data_ready), 32'(ready));
    endtask

    task automatic expectCrcBeat(input string tag, input logic [15:0] code, input logic [3:0] dqs);
        checkOutput({tag, "_dq"},    32'(o_DQ),         32'(code));
        checkOutput({tag, "_dqv"},   32'(o_DQ_valid),   32'h1);
        checkOutput({tag, "_dm"},    32'(o_DM),         32'h0);
        checkOutput({tag, "_dqs"},   32'(o_DQS),        32'(dqs));
        checkOutput({tag, "_crcen"}, 32'(o_crc_enable), 32'h0);
        checkOutput({tag, "_ready"}, 32'(o_data_ready), 32'h0);
    endtask

    // Issue one command from IDLE; returns in the first preamble cycle.
    task automatic applyStimulus(input logic [1:0] bl, input logic [2:0] pre,
                                 input logic [1:0] post, input logic [7:0] prePat,
                                 input logic [3:0] postPat, input logic crc);
        i_burstlength  = bl;
        i_precycle     = pre;
        i_postcycle    = post;
        i_pre_pattern  = prePat;
        i_post_pattern = postPat;
        i_DRAM_crc_en  = crc;
        i_wr_en        = 1'b1;
        busyCycles     = 0;
        crcCycles      = 0;
        tick();
        i_wr_en = 1'b0;
    endtask

    // Walks data beats firstJ..lastJ; beat j of burst id carries beatData(id, j)
    // and the bench presents the following beat while o_data_ready is expected.
    task automatic runDataBeats(input string tag, input int id, input int firstJ,
                                input int lastJ, input int total, input int parityBase,
                                input int maskBeat, input logic [1:0] maskVal,
                                input logic [1:0] defMask);
        for (int j = firstJ; j <= lastJ; j++) begin
            tick();
            i_wr_en = 1'b0;
            expectBeat($sformatf("%s_b%0d", tag, j), beatData(id, j),
                       (j == maskBeat) ? maskVal : defMask, dqsFor(parityBase + j),
                       (j < total - 1));
            i_Wr_data     = beatData(id, j + 1);
            i_Wr_datamask = (j + 1 == maskBeat) ? maskVal : defMask;
        end
    endtask

    initial begin
        i_rst          = 1'b1;
        i_enable       = 1'b1;
        i_wr_en        = 1'b0;
        i_burstlength  = 2'b00;
        i_precycle     = 3'd0;
        i_postcycle    = 2'd0;
        i_pre_pattern  = '0;
        i_post_pattern = '0;
        i_DRAM_crc_en  = 1'b0;
        i_Wr_data      = '0;
        i_Wr_datamask  = '0;
        i_crc_code     = '0;
        tick();
        tick();
        checkIdle("reset");
        i_rst = 1'b0;
        tick();
        checkIdle("after_reset");

        // BL16, pre=2, post=1, no CRC: 19 busy cycles.
        $display("[TB] test 1: BL16 with preamble and postamble");
        applyStimulus(2'b00, 3'd2, 2'd1, 8'b0000_0110, 4'b1011, 1'b0);
        expectDqs("t1_pre0", 4'b1010, 1'b0);
        tick();
        expectDqs("t1_pre1", 4'b0101, 1'b1);
        i_Wr_data = beatData(1, 0);
        runDataBeats("t1", 1, 0, 15, 16, 0, -1, 2'b00, 2'b00);
        tick();
        expectDqs("t1_post0", 4'b1111, 1'b0);
        tick();
        checkIdle("t1_end");
        checkOutput("t1_busy_cycles", 32'(busyCycles), 32'd19);

        // BL32 with CRC, mask held high: CRC beats must drive code and DM=0.
        $display("[TB] test 2: BL32 with CRC");
        applyStimulus(2'b10, 3'd1, 2'd0, 8'b0000_0010, 4'b0000, 1'b1);
        expectDqs("t2_pre0", 4'b1010, 1'b1);
        i_Wr_data     = beatData(2, 0);
        i_Wr_datamask = 2'b11;
        runDataBeats("t2", 2, 0, 31, 32, 0, -1, 2'b00, 2'b11);
        i_crc_code = 16'hC1C2;
        tick();
        expectCrcBeat("t2_crc0", 16'hC1C2, 4'b1010);
        i_crc_code = 16'h3C4D;
        tick();
        expectCrcBeat("t2_crc1", 16'h3C4D, 4'b0101);
        tick();
        checkIdle("t2_end");
        checkOutput("t2_crcen_cycles", 32'(crcCycles), 32'd32);
        checkOutput("t2_busy_cycles", 32'(busyCycles), 32'd35);
        i_Wr_datamask = 2'b00;

        // BC8, pre=0 behaves as 1, post=3 clamps to 2, mask only on beat 3.
        $display("[TB] test 3: BC8 with mask and clamping");
        applyStimulus(2'b01, 3'd0, 2'd3, 8'b0000_0001, 4'b0111, 1'b0);
        expectDqs("t3_pre0", 4'b0101, 1'b1);
        i_Wr_data     = beatData(3, 0);
        i_Wr_datamask = 2'b00;
        runDataBeats("t3", 3, 0, 7, 8, 0, 3, 2'b01, 2'b00);
        tick();
        expectDqs("t3_post0", 4'b1111, 1'b0);
        tick();
        expectDqs("t3_post1", 4'b0101, 1'b0);
        tick();
        checkIdle("t3_end");
        checkOutput("t3_busy_cycles", 32'(busyCycles), 32'd11);

        // Seamless BL16 pair: 32 contiguous beats, second command's post=2.
        $display("[TB] test 4: seamless back-to-back BL16");
        applyStimulus(2'b00, 3'd2, 2'd1, 8'b0000_0110, 4'b1011, 1'b0);
        expectDqs("t4_pre0", 4'b1010, 1'b0);
        tick();
        expectDqs("t4_pre1", 4'b0101, 1'b1);
        i_Wr_data = beatData(4, 0);
        runDataBeats("t4a", 4, 0, 14, 16, 0, -1, 2'b00, 2'b00);
        tick();
        i_wr_en        = 1'b1;
        i_postcycle    = 2'd2;
        i_post_pattern = 4'b0110;
        i_Wr_data      = beatData(7, 0);
        #1;
        expectBeat("t4a_b15", beatData(4, 15), 2'b00, dqsFor(15), 1'b1);
        runDataBeats("t4b", 7, 0, 15, 16, 16, -1, 2'b00, 2'b00);
        tick();
        expectDqs("t4_post0", 4'b1010, 1'b0);
        tick();
        expectDqs("t4_post1", 4'b0101, 1'b0);
        tick();
        checkIdle("t4_end");
        checkOutput("t4_busy_cycles", 32'(busyCycles), 32'd36);

        // Freeze for 3 cycles on beat 5; garbage data during the freeze
        // must not be captured.
        $display("[TB] test 5: enable low mid-burst");
        applyStimulus(2'b00, 3'd1, 2'd0, 8'b0000_0010, 4'b0000, 1'b0);
        expectDqs("t5_pre0", 4'b1010, 1'b1);
        i_Wr_data = beatData(5, 0);
        runDataBeats("t5", 5, 0, 5, 16, 0, -1, 2'b00, 2'b00);
        i_enable  = 1'b0;
        i_Wr_data = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            expectBeat($sformatf("t5_frz%0d", k), beatData(5, 5), 2'b00, dqsFor(5), 1'b1);
        end
        i_Wr_data = beatData(5, 6);
        i_enable  = 1'b1;
        runDataBeats("t5", 5, 6, 15, 16, 0, -1, 2'b00, 2'b00);
        tick();
        checkIdle("t5_end");
        checkOutput("t5_busy_cycles", 32'(busyCycles), 32'd20);

        // Reset on beat 5, then a clean BC8+CRC command with pre=7 -> 4.
        $display("[TB] test 6: reset mid-burst then restart");
        applyStimulus(2'b00, 3'd1, 2'd1, 8'b0000_0010, 4'b0011, 1'b0);
        expectDqs("t6_pre0", 4'b1010, 1'b1);
        i_Wr_data = beatData(6, 0);
        runDataBeats("t6a", 6, 0, 5, 16, 0, -1, 2'b00, 2'b00);
        i_rst = 1'b1;
        tick();
        checkIdle("t6_rst");
        i_rst = 1'b0;
        applyStimulus(2'b01, 3'd7, 2'd0, 8'b0001_1011, 4'b0000, 1'b1);
        expectDqs("t6_pre0b", 4'b1111, 1'b0);
        tick();
        expectDqs("t6_pre1b", 4'b1010, 1'b0);
        tick();
        expectDqs("t6_pre2b", 4'b0101, 1'b0);
        tick();
        expectDqs("t6_pre3b", 4'b0000, 1'b1);
        i_Wr_data = beatData(8, 0);
        runDataBeats("t6b", 8, 0, 7, 8, 0, -1, 2'b00, 2'b00);
        i_crc_code = 16'h5A5A;
        tick();
        expectCrcBeat("t6_crc0", 16'h5A5A, 4'b1010);
        i_crc_code = 16'hA5A5;
        tick();
        expectCrcBeat("t6_crc1", 16'hA5A5, 4'b0101);
        tick();
        checkIdle("t6_end");
        checkOutput("t6_busy_cycles", 32'(busyCycles), 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
